// File: rtl/ps2_mouse_tx.sv
// PS/2 mouse-side transmitter: packs a report into 3 frames and drives clock/data.
// Optional host-inhibit abort/retry under PS2_MOUSE_TX_INHIBIT_EN.
module ps2_mouse_tx #(
    parameter int CLK_HALF = 2000,
    parameter int GAP      = 2000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       pkt_valid,
    output logic       pkt_ready,
    input  logic [8:0] dx,
    input  logic [8:0] dy,
    input  logic [2:0] btn,
    input  logic       ps2_clk_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy
);

    localparam int MAXV = (CLK_HALF > GAP) ? CLK_HALF : GAP;
    localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;
    localparam logic [CW-1:0] HALF_END = CW'(CLK_HALF - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(GAP - 1);

`ifdef PS2_MOUSE_TX_INHIBIT_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_GAP,
        S_INHIBIT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_GAP
    } state_t;
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [8:0]    dx_q;
    logic [8:0]    dy_q;
    logic [2:0]    btn_q;
    logic [7:0]    cur_byte;
    logic [15:0]   frame;
    logic          next_bit;
    logic          accept;

    assign accept = pkt_valid && pkt_ready;

    always_comb begin
        cur_byte = dy_q[7:0];
        case (byte_idx)
            2'd0:    cur_byte = {2'b00, dy_q[8], dx_q[8], 1'b1, btn_q};
            2'd1:    cur_byte = dx_q[7:0];
            default: cur_byte = dy_q[7:0];
        endcase
    end

    // Padded with ones so the look-ahead index never leaves the vector.
    assign frame    = {5'b11111, ~^cur_byte, cur_byte, 1'b0};
    assign next_bit = frame[bit_idx + 4'd1];

`ifdef PS2_MOUSE_TX_INHIBIT_EN
    logic clk_s1;
    logic clk_s2;
    logic low_seen;
    logic inh_ok;
    logic abort;

    // The final gap is not interruptible: the packet is already complete.
    assign inh_ok = (state == S_SETUP) ||
                    (state == S_GAP && byte_idx != 2'd2);
    assign abort  = inh_ok && !clk_s2 && low_seen;

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            low_seen <= 1'b0;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            low_seen <= inh_ok && !clk_s2;
        end
    end
`else
    logic unused_clk;
    assign unused_clk = ps2_clk_in;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            btn_q      <= '0;
            pkt_ready  <= 1'b1;
            busy       <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end
`ifdef PS2_MOUSE_TX_INHIBIT_EN
        else if (abort) begin
            state      <= S_INHIBIT;
            cnt        <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end
`endif
        else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        dx_q       <= dx;
                        dy_q       <= dy;
                        btn_q      <= btn;
                        state      <= S_SETUP;
                        cnt        <= '0;
                        bit_idx    <= '0;
                        byte_idx   <= '0;
                        pkt_ready  <= 1'b0;
                        busy       <= 1'b1;
                        ps2_dat_oe <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (cnt == HALF_END) begin
                        cnt        <= '0;
                        state      <= S_LOW;
                        ps2_clk_oe <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_LOW: begin
                    if (cnt == HALF_END) begin
                        cnt        <= '0;
                        ps2_clk_oe <= 1'b0;
                        if (bit_idx == 4'd10) begin
                            state      <= S_GAP;
                            ps2_dat_oe <= 1'b0;
                        end else begin
                            bit_idx    <= bit_idx + 4'd1;
                            state      <= S_SETUP;
                            ps2_dat_oe <= ~next_bit;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_END) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (byte_idx == 2'd2) begin
                            state     <= S_IDLE;
                            pkt_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            byte_idx   <= byte_idx + 2'd1;
                            state      <= S_SETUP;
                            ps2_dat_oe <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef PS2_MOUSE_TX_INHIBIT_EN
                S_INHIBIT: begin
                    if (!clk_s2) begin
                        cnt <= '0;
                    end else if (cnt == GAP_END) begin
                        cnt        <= '0;
                        bit_idx    <= '0;
                        byte_idx   <= '0;
                        state      <= S_SETUP;
                        ps2_dat_oe <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                default: begin
                    state      <= S_IDLE;
                    pkt_ready  <= 1'b1;
                    busy       <= 1'b0;
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ps2_mouse_tx.md
# ps2_mouse_tx

- Device-side PS/2 mouse packet transmitter. It is the mouse end of the link our PS/2 host receiver and packet decoder consume.
- Accepts one movement/button report per handshake and packs it into the standard 3-byte mouse packet.
- Serializes each byte as an 11-bit PS/2 frame, generating the PS/2 clock itself, through open-drain enables.
- Used as an on-board mouse emulator and as a bench driver for the cursor path.

## Interface

Parameters:
- CLK_HALF, 2000: CLOCK_50 cycles per PS/2 clock half-period (12.5 kHz).
- GAP, 2000: idle cycles (clock and data released) after every byte.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset_n  in  1  reset; **one clock, synchronous, active-low**.
- pkt_valid  in  1  report available.
- pkt_ready  out  1  transmitter can accept a report.
- dx  in  9  signed X movement, two's complement.
- dy  in  9  signed Y movement, two's complement.
- btn  in  3  {middle, right, left}, 1 = pressed.
- ps2_clk_in  in  1  sensed PS2_CLK line (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low, 0 = release.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low, 0 = release.
- busy  out  1  packet in flight.

## Operation

- Accept a report on a rising edge with pkt_valid & pkt_ready.
  - dx, dy and btn are registered on that edge.
  - pkt_ready drops the next cycle.
- Packet bytes, in order:
  - byte1 = {2'b00, dy[8], dx[8], 1'b1, btn[2], btn[1], btn[0]}; overflow bits are always 0.
  - byte2 = dx[7:0].
  - byte3 = dy[7:0].
- Frame per byte, 11 bits: start 0, data bits 0..7 (LSB first), odd parity, stop 1.
  - The parity bit makes the count of ones over data + parity odd.
- Line encoding: ps2_dat_oe = ~bit; ps2_clk_oe = 1 only in LOW.
- FSM states: IDLE, SETUP, LOW, GAP.
  - IDLE: pkt_ready = 1, both oe = 0. On accept → SETUP, bit index 0, byte index 0.
  - SETUP: clock released, data driven with the current bit, CLK_HALF cycles → LOW.
  - LOW: clock pulled low, data held, CLK_HALF cycles.
    - bit index < 10 → increment bit index, → SETUP.
    - bit index = 10 → GAP.
  - GAP: both oe = 0, GAP cycles.
    - byte index < 2 → next byte, bit index 0, → SETUP.
    - byte index = 2 → IDLE.
- Data only changes at SETUP entry, while the clock is high. The host samples on the falling edge.
- busy = (state != IDLE).
- pkt_valid outside IDLE is ignored; no queuing.
- ps2_clk_in passes through a 2-flop synchronizer. It is used only under the Configuration macro.

## Timing

- Reset values: pkt_ready = 1, busy = 0, ps2_clk_oe = 0, ps2_dat_oe = 0, state IDLE, all counters 0.
- Reset mid-packet: lines are released on the reset edge. No partial frame is resumed.
- Accept on edge N:
  - ps2_dat_oe = 1 (start bit) from cycle N+1.
  - First ps2_clk_oe rise at N+1+CLK_HALF.
- Per byte: 22·CLK_HALF cycles, then GAP cycles.
- pkt_ready returns at N+1+3·(22·CLK_HALF+GAP). With defaults this is N+138001.
- Back-to-back: a report held valid during the IDLE cycle is accepted that same cycle. The minimum spacing between accepts is 3·(22·CLK_HALF+GAP)+1 cycles.
- Counter widths hold max(CLK_HALF, GAP)−1. A parameter value of 0 is illegal.

## Configuration

PS2_MOUSE_TX_INHIBIT_EN

Defined: host inhibit is honoured.
- A synchronized ps2_clk_in = 0 for 2 consecutive cycles in SETUP or GAP aborts the packet.
  - LOW is excluded because the transmitter drives the clock itself.
  - Inhibit during GAP after the third byte is ignored.
- On abort: both oe go to 0 on the next cycle and the FSM enters INHIBIT.
- INHIBIT leaves once ps2_clk_in has been high for GAP consecutive cycles.
- It then restarts the stored packet from byte1 bit 0.
- pkt_ready stays 0 throughout, and busy = 1.

Undefined:
- ps2_clk_in is ignored; the INHIBIT state and the synchronizer are absent.
- Packets always complete.

## Test plan

- Reset: hold reset_n=0 for 3 cycles with pkt_valid=1 → pkt_ready=1, busy=0, both oe=0. No accept occurs.
- Packet: dx=+5, dy=−3, btn=3'b001, CLK_HALF=4, GAP=4.
  - Frames sampled on ps2_clk_oe rises carry 0x29 (parity 0), 0x05 (parity 1), 0xFD (parity 0).
  - Each frame has start 0 and stop 1.
- Latency with the same parameters: accept at edge N → pkt_ready=1 again at N+1+3·(88+4) = N+277.
  - Exactly 33 ps2_clk_oe pulses of 4 cycles each.
- Back-to-back: pkt_valid held high with values changing every cycle → the second packet carries the values present on the re-accept cycle. The pkt_valid pulse in mid-packet is dropped.
- Reset mid-byte: reset_n=0 during the 5th LOW of byte2 → oe=0 on the reset edge, pkt_ready=1 after.
  - A new packet then starts cleanly with byte1.
- With PS2_MOUSE_TX_INHIBIT_EN: drive ps2_clk_in=0 for 10 cycles during byte2 SETUP → lines are released, then ps2_clk_in=1.
  - After GAP cycles, a full retransmit of byte1, byte2 and byte3.
  - pkt_ready stays low until the end of that retransmit.
